// File: rtl/mult_div_seq_32.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_seq_32 (with helper rc_add_sub_32)
//  Purpose  : Sequential 32-bit unsigned multiplier / divider. One operation
//             takes 32 iterations through a single shared ripple-carry
//             adder/subtractor (shift-add multiply, restoring-style divide).
//  Ports    : clk    - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             start  - request, sampled only while idle
//             op     - 0 = multiply, 1 = divide (sampled with start)
//             a, b   - multiplicand/dividend, multiplier/divisor
//             busy   - high while running and during the done cycle
//             done   - one-cycle completion strobe
//             hi, lo - MUL: product[63:32]/[31:0]; DIV: remainder/quotient
//             dz     - divide-by-zero flag of the last operation
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 32-bit ripple-carry adder/subtractor. sna=1 computes a - b as a + ~b + 1;
// co is then the "no borrow" flag (a >= b).
// ----------------------------------------------------------------------------
module rc_add_sub_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sna,
  output logic [31:0] s,
  output logic        co
);
  localparam int DATA_INDEX_LIMIT = 31;

  logic [DATA_INDEX_LIMIT:0]   w_b;
  logic [DATA_INDEX_LIMIT+1:0] w_c;

  assign w_b    = b ^ {32{sna}};
  assign w_c[0] = sna;

  generate
    for (genvar i = 0; i <= DATA_INDEX_LIMIT; i++) begin : g_bit
      assign s[i]     = a[i] ^ w_b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & w_b[i]) | (w_c[i] & (a[i] ^ w_b[i]));
    end
  endgenerate

  assign co = w_c[DATA_INDEX_LIMIT+1];
endmodule

module mult_div_seq_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz
);
  localparam int DATA_INDEX_LIMIT = 31;
  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                    r_op;
  logic [DATA_INDEX_LIMIT:0] r_m;
  logic [4:0]              r_cnt;
  logic [DATA_INDEX_LIMIT:0] r_hi;
  logic [DATA_INDEX_LIMIT:0] r_lo;
  logic                    r_dz;

  // Shared adder operands. For divide the partial remainder is shifted left
  // by one bit pulling in the next dividend bit; the bit shifted out of HI
  // (w_msb) means the shifted value is >= 2^32 and thus always >= M.
  logic [DATA_INDEX_LIMIT:0] w_div_t;
  logic                    w_msb;
  logic [DATA_INDEX_LIMIT:0] w_add_a;
  logic [DATA_INDEX_LIMIT:0] w_add_b;
  logic [DATA_INDEX_LIMIT:0] w_sum;
  logic                    w_co;
  logic                    w_take;

  assign w_div_t = {r_hi[30:0], r_lo[31]};
  assign w_msb   = r_hi[31];
  assign w_add_a = r_op ? w_div_t : r_hi;
  assign w_add_b = r_op ? r_m : (r_lo[0] ? r_m : '0);
  assign w_take  = w_msb | w_co;

  rc_add_sub_32 u_addsub (
    .a   (w_add_a),
    .b   (w_add_b),
    .sna (r_op),
    .s   (w_sum),
    .co  (w_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_ITER) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= 1'b0;
      r_m   <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_m   <= b;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= a;
            r_dz  <= op & (b == '0);
          end
        end
        S_RUN: begin
          if (r_op) begin
            r_hi <= w_take ? w_sum : w_div_t;
            r_lo <= {r_lo[30:0], w_take};
          end else begin
            {r_hi, r_lo} <= {w_co, w_sum, r_lo[31:1]};
          end
          // Hold at the last iteration so the counter never wraps.
          if (r_cnt != LAST_ITER) r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;
  assign dz = r_dz;
endmodule
`default_nettype wire

// File: tb/tb_mult_div_seq_32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_seq_32
//  Purpose  : Self-checking bench for mult_div_seq_32 against an arithmetic
//             reference model (a*b, a/b, a%b, divide-by-zero convention).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_seq_32;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_seq_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic.
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
    logic [63:0] p;
    if (!o) begin
      p    = {32'd0, x} * {32'd0, y};
      e_hi = p[63:32];
      e_lo = p[31:0];
      e_dz = 1'b0;
    end else if (y == 32'd0) begin
      e_hi = x;
      e_lo = 32'hFFFF_FFFF;
      e_dz = 1'b1;
    end else begin
      e_hi = x % y;
      e_lo = x / y;
      e_dz = 1'b0;
    end
  endtask

  // Present a request for one edge; returns just after the accepting edge.
  task automatic accept(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
  endtask

  // Counts edges after the accept until done (bounded), optionally pulsing a
  // competing start at cycle 10.
  task automatic wait_done(output int n, input bit intrude);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (intrude && n == 10) begin
        start = 1'b1; op = 1'b1; a = 32'hDEAD_BEEF; b = 32'd3;
      end
      if (intrude && n == 11) begin
        start = 1'b0;
        chk("busy_after_intrude", {63'd0, busy}, 64'd1);
      end
      if (done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input bit intrude);
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          n;
    model(o, x, y, e_hi, e_lo, e_dz);
    accept(o, x, y);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(n, intrude);
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_res"}, {hi, lo}, {e_hi, e_lo});
    chk({tag, "_dz"}, {63'd0, dz}, {63'd0, e_dz});
    // done is a single-cycle strobe; results then hold while idle.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    end
    chk({tag, "_hold"}, {31'd0, dz, hi, lo}, {31'd0, e_dz, e_hi, e_lo});
  endtask

  initial begin
    int n;
    logic        ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #2;
    chk("reset_state", {60'd0, busy, done, dz, |{hi, lo}}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {62'd0, busy, done}, 64'd0);

    // Directed cases
    run_op("mul_3x5",   1'b0, 32'd3,          32'd5,          1'b0);
    run_op("mul_max",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0);
    run_op("div_100_7", 1'b1, 32'd100,        32'd7,          1'b0);
    run_op("div_msb",   1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  1'b0);
    run_op("div_zero",  1'b1, 32'h1234_5678,  32'd0,          1'b0);
    run_op("mul_zero",  1'b0, 32'h1234_5678,  32'd0,          1'b0);
    run_op("div_by1",   1'b1, 32'hCAFE_F00D,  32'd1,          1'b0);
    run_op("div_small", 1'b1, 32'd5,          32'd9,          1'b0);

    // Start pulse during RUN is ignored and not queued.
    run_op("intrude",   1'b0, 32'h0001_0003,  32'h0002_0005,  1'b1);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      run_op("rand", ro, ra, rb, 1'b0);
    end

    // Reset asserted mid-RUN aborts with no done strobe.
    accept(1'b0, 32'hFFFF_0000, 32'h1234_5678);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
    end
    chk("busy_before_abort", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {28'd0, busy, done, dz, 1'b0, hi, lo}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    chk("no_done_after_abort", 64'(n), 64'd0);
    run_op("mul_6x7", 1'b0, 32'd6, 32'd7, 1'b0);

    // Start held high continuously: back-to-back operations from IDLE.
    start = 1'b1; op = 1'b0; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    wait_done(n, 1'b0);
    chk("held_lat1", 64'(n), 64'd32);
    chk("held_res1", {hi, lo}, 64'd143);
    @(posedge clk); #1;   // back in IDLE, start still high
    @(posedge clk); #1;   // accepted again
    chk("held_reaccept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    wait_done(n, 1'b0);
    chk("held_lat2", 64'(n), 64'd32);
    chk("held_res2", {hi, lo}, 64'd143);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
